// File: rtl/ex_dmem_req.sv
// EX-stage data-memory request unit: decodes the memory op into an SRAM-like
// bus request, stalls the pipeline until the access completes, captures load data.
module ex_dmem_req (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [11:0] ex_memop_i,
  input  logic [31:0] ex_memaddr_i,
  input  logic [31:0] ex_storedata_i,
  input  logic        ex_stall_i,
  input  logic        ex_flush_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_wstrb_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] ex_rdata_o,
  output logic        ex_adel_o,
  output logic        ex_ades_o,
  output logic        ex_stallreq_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_rdata;
  logic        r_is_load;

  logic        w_lb, w_lbu, w_lh, w_lhu, w_lw, w_sb, w_sh, w_sw;
  logic        w_lwl, w_lwr, w_swl, w_swr;
  logic [1:0]  w_a;
  logic        w_adel, w_ades, w_start, w_is_store, w_req;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign {w_swr, w_swl, w_lwr, w_lwl, w_sw, w_sh, w_sb, w_lw, w_lhu, w_lh, w_lbu, w_lb} = ex_memop_i;
  assign w_a        = ex_memaddr_i[1:0];
  assign w_adel     = ((w_lh | w_lhu) & w_a[0]) | (w_lw & (w_a != 2'b00));
  assign w_ades     = (w_sh & w_a[0]) | (w_sw & (w_a != 2'b00));
  assign w_start    = ex_valid_i & (|ex_memop_i) & ~w_adel & ~w_ades & ~ex_flush_i;
  assign w_is_store = w_sb | w_sh | w_sw | w_swl | w_swr;

  // Size and address decode; unaligned-word ops address the containing word
  always_comb begin
    w_size = 2'd2;
    w_addr = ex_memaddr_i;
    if (w_lb | w_lbu | w_sb) begin
      w_size = 2'd0;
    end else if (w_lh | w_lhu | w_sh) begin
      w_size = 2'd1;
    end else begin
      w_size = 2'd2;
    end
    if (w_lwl | w_lwr | w_swl | w_swr) begin
      w_addr = {ex_memaddr_i[31:2], 2'b00};
    end else begin
      w_addr = ex_memaddr_i;
    end
  end

  // Store byte strobes and lane-aligned store data
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0000_0000;
    if (w_sb) begin
      w_wstrb = 4'b0001 << w_a;
      w_wdata = {4{ex_storedata_i[7:0]}};
    end else if (w_sh) begin
      w_wstrb = w_a[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{ex_storedata_i[15:0]}};
    end else if (w_sw) begin
      w_wstrb = 4'b1111;
      w_wdata = ex_storedata_i;
    end else if (w_swl) begin
      // swl writes the high end of rt into the low lanes up to the addressed byte
      w_wstrb = 4'b1111 >> ~w_a;
      w_wdata = ex_storedata_i >> {~w_a, 3'b000};
    end else if (w_swr) begin
      w_wstrb = 4'b1111 << w_a;
      w_wdata = ex_storedata_i << {w_a, 3'b000};
    end else begin
      w_wstrb = 4'b0000;
      w_wdata = 32'h0000_0000;
    end
  end

  // Request and stall generation from the current state
  always_comb begin
    w_req         = 1'b0;
    ex_stallreq_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req         = w_start;
        ex_stallreq_o = w_start;
      end
      S_REQ: begin
        w_req         = 1'b1;
        ex_stallreq_o = 1'b1;
      end
      S_WAIT:  ex_stallreq_o = ~data_data_ok_i;
      S_DONE:  ex_stallreq_o = 1'b0;
      S_DRAIN: ex_stallreq_o = w_start;
      default: begin
        w_req         = 1'b0;
        ex_stallreq_o = 1'b0;
      end
    endcase
  end

  assign data_req_o   = w_req;
  assign data_wr_o    = w_req & w_is_store;
  assign data_size_o  = w_req ? w_size  : 2'd0;
  assign data_addr_o  = w_req ? w_addr  : 32'h0000_0000;
  assign data_wstrb_o = (w_req & w_is_store) ? w_wstrb : 4'b0000;
  assign data_wdata_o = (w_req & w_is_store) ? w_wdata : 32'h0000_0000;
  assign ex_adel_o    = w_adel;
  assign ex_ades_o    = w_ades;
  assign ex_rdata_o   = r_rdata;

  // Request/response FSM and load data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rdata   <= 32'h0000_0000;
      r_is_load <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_load <= ~w_is_store;
            r_state   <= data_addr_ok_i ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          // acceptance wins over a simultaneous flush: the response must be drained
          if (data_addr_ok_i) begin
            r_state <= ex_flush_i ? S_DRAIN : S_WAIT;
          end else if (ex_flush_i) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (data_data_ok_i) begin
            if (~ex_flush_i & r_is_load) begin
              r_rdata <= data_rdata_i;
            end
            r_state <= (ex_flush_i | ~ex_stall_i) ? S_IDLE : S_DONE;
          end else if (ex_flush_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (~ex_stall_i | ex_flush_i) begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (data_data_ok_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_dmem_req.md
# ex_dmem_req

Data-memory request unit in the EX stage, directly upstream of the MEM stage.
- Decodes the EX memory op into an SRAM-like bus request: address, size, byte strobes and aligned store data.
- Runs a request/response FSM and holds the pipeline via a stall request until the access completes.
- Captures load data for the MEM stage, whose alignment/extension logic consumes it.
- Handles flush with an outstanding transaction by draining the response.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  EX holds a valid instruction
- ex_memop_i  in  12  one-hot: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw, 8 lwl, 9 lwr, 10 swl, 11 swr
- ex_memaddr_i  in  32  effective address
- ex_storedata_i  in  32  rt value
- ex_stall_i  in  1  EX cannot advance next edge (downstream stall)
- ex_flush_i  in  1  squash current EX instruction
- data_req_o  out  1  bus request
- data_wr_o  out  1  1 = store
- data_size_o  out  2  0 byte, 1 half, 2 word
- data_addr_o  out  32  bus address
- data_wstrb_o  out  4  byte strobes (0 for loads)
- data_wdata_o  out  32  lane-aligned store data
- data_addr_ok_i  in  1  request accepted this cycle
- data_data_ok_i  in  1  response this cycle
- data_rdata_i  in  32  load data, valid with data_ok
- ex_rdata_o  out  32  captured load word, registered
- ex_adel_o  out  1  load address error, combinational
- ex_ades_o  out  1  store address error, combinational
- ex_stallreq_o  out  1  hold pipeline

## Operation
Decode:
- start = ex_valid_i & |ex_memop_i & ~adel & ~ades & ~ex_flush_i.
- adel: (lh|lhu) & a[0], or lw & a[1:0]≠0. ades: sh & a[0], or sw & a[1:0]≠0. lwl/lwr/swl/swr never fault. No request on fault.
- data_size_o: lb/lbu/sb → 0; lh/lhu/sh → 1; others → 2.
- data_addr_o: lwl/lwr/swl/swr → {a[31:2],2'b00}; others → a.

Store strobes/data (a = a[1:0], rt = ex_storedata_i):
- sb: wstrb = 1<<a; wdata = {4{rt[7:0]}}.
- sh: wstrb = 0011 (a[1]=0) / 1100; wdata = {2{rt[15:0]}}.
- sw: wstrb = 1111; wdata = rt.
- swl a=00..11: 0001 {24'b0,rt[31:24]}; 0011 {16'b0,rt[31:16]}; 0111 {8'b0,rt[31:8]}; 1111 rt.
- swr a=00..11: 1111 rt; 1110 {rt[23:0],8'b0}; 1100 {rt[15:0],16'b0}; 1000 {rt[7:0],24'b0}.

FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: data_req_o = start.
  - start & addr_ok → WAIT.
  - start & ~addr_ok → REQ.
- REQ: data_req_o = 1; bus fields recomputed from EX inputs, which are stable because the stall holds EX.
  - addr_ok → WAIT.
  - flush & ~addr_ok → IDLE, request withdrawn.
  - flush & addr_ok → DRAIN.
- WAIT: on data_ok, rdata_q ← data_rdata_i (loads only, not flushed).
  - data_ok & ~ex_stall_i → IDLE.
  - data_ok & ex_stall_i → DONE.
  - flush & ~data_ok → DRAIN.
  - flush & data_ok → IDLE, data discarded.
- DONE: no request; the same instruction is not reissued.
  - ~ex_stall_i or flush → IDLE.
- DRAIN: data_req_o = 0; new starts blocked.
  - data_ok → IDLE, data discarded.

ex_stallreq_o = (IDLE & start) | REQ | (WAIT & ~data_ok) | (DRAIN & start). It is 0 in DONE.

## Timing
- Reset: state IDLE; data_req_o 0; ex_stallreq_o 0; rdata_q (ex_rdata_o) 0. Bus outputs otherwise follow combinational decode, gated to 0 when data_req_o = 0.
- Reset mid-transaction returns to IDLE immediately. Any later data_ok is ignored in IDLE.
- Best-case latency: request and addr_ok in cycle 0, data_ok in cycle 1. The stall is released in cycle 1 and ex_rdata_o is valid from cycle 2.
- At most one outstanding transaction. data_ok is only honoured in WAIT/DRAIN; in IDLE/REQ/DONE it is ignored.
- Stores capture nothing; rdata_q keeps its prior value.
- Simultaneous addr_ok and flush in REQ: the transaction counts as accepted, so the state goes to DRAIN.

## Test plan
- lb at 0x1003, addr_ok same cycle, data_ok next cycle with 0xAABBCCDD → data_addr_o 0x1003, size 0, stallreq high exactly 1 cycle, then ex_rdata_o = 0xAABBCCDD.
- swr at 0x2001, rt 0x11223344 → data_addr_o 0x2000, wstrb 1110, wdata 0x22334400, wr 1. swl at 0x2002 → wstrb 0111, wdata 0x00112233.
- lw at 0x3002 → ex_adel_o 1, data_req_o 0, stallreq 0. sh at 0x3001 → ex_ades_o 1, no request.
- addr_ok withheld 3 cycles → data_req_o and fields stable for 4 cycles, stallreq held until data_ok.
- Flush in WAIT with data_ok 2 cycles later; a new lw is presented meanwhile → no request until data_ok, stallreq high, rdata_q unchanged. The new lw issues the cycle after the drain.
- data_ok with ex_stall_i high for 2 cycles → DONE, no reissue, stallreq 0. Returns to IDLE when ex_stall_i drops.
